// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM states, SPI mode bits
// and the chip-select ceiling.
package spi_pkg;

  localparam int MAX_CS = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    DONE
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: one tick every CLK_DIV cycles while enabled,
// split into leading/trailing edge strobes during the shift phase.
module spi_clk_gen #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic xfer,
  output logic tick,
  output logic lead,
  output logic trail,
  output logic last_edge
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W) + 1;

  logic [DIV_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;

  assign tick = en && (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!en || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
    end else if (!xfer) begin
      edge_cnt <= '0;
    end else if (tick) begin
      edge_cnt <= edge_cnt + EDGE_W'(1);
    end
  end

  assign lead      = xfer && tick && !edge_cnt[0];
  assign trail     = xfer && tick && edge_cnt[0];
  assign last_edge = trail &&
    (edge_cnt == EDGE_W'(2 * DATA_W - 1));

endmodule

// File: rtl/spi_master_param.sv
// Parameterised SPI master, all four modes, NUM_CS selects.
// Define SPI_LOOPBACK_EN to feed mosi back as the receive source.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4,
  parameter int NUM_CS  = 2,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs_n,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done
);

  state_t            state, state_nxt;
  spi_mode_t         mode;
  logic [CS_W-1:0]   sel;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic              mosi_q, sclk_q, armed;
  logic              tick, lead, trail, last_edge;
  logic              active, accept;
  logic              shift_en, sample_en, miso_int;

  assign active = state inside {SETUP, XFER, HOLD};
  assign accept = armed && start &&
    (state == IDLE || state == DONE);

  assign shift_en  = mode.cpha ? lead : trail;
  assign sample_en = mode.cpha ? trail : lead;

`ifdef SPI_LOOPBACK_EN
  assign miso_int = mosi_q;
`else
  assign miso_int = miso;
`endif

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (DATA_W)
  ) u_clk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (active),
    .xfer      (state == XFER),
    .tick      (tick),
    .lead      (lead),
    .trail     (trail),
    .last_edge (last_edge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   if (tick) state_nxt = XFER;
      XFER:    if (last_edge) state_nxt = HOLD;
      HOLD:    if (tick) state_nxt = DONE;
      DONE:    state_nxt = accept ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Out-of-range selects leave every line deasserted.
  always_comb begin
    busy = active;
    done = (state == DONE);
    mosi = active ? mosi_q : 1'b0;
    sclk = sclk_q;
    cs_n = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (active && int'(sel) == i) cs_n[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode    <= '0;
      sel     <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      mosi_q  <= 1'b0;
      sclk_q  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        mode.cpol <= cpol;
        mode.cpha <= cpha;
        sel       <= cs_sel;
        rx_sr     <= '0;
        sclk_q    <= cpol;
        // cpha=0 presents the MSB before the first edge.
        if (cpha) begin
          tx_sr  <= tx_data;
          mosi_q <= 1'b0;
        end else begin
          tx_sr  <= tx_data << 1;
          mosi_q <= tx_data[DATA_W-1];
        end
      end else begin
        if (!active) begin
          sclk_q <= cpol;
        end else if (state != XFER) begin
          sclk_q <= mode.cpol;
        end else if (tick) begin
          sclk_q <= ~sclk_q;
        end
        if (shift_en) begin
          mosi_q <= tx_sr[DATA_W-1];
          tx_sr  <= tx_sr << 1;
        end
        if (sample_en) begin
          rx_sr <= {rx_sr[DATA_W-2:0], miso_int};
        end
        if (state == HOLD && tick) begin
          rx_data <= rx_sr;
        end
      end
    end
  end

endmodule
